branch_pred_unit: RTL and testbench

Parametrised dynamic branch predictor with misprediction recovery, the successor to the fixed one-bit predicted-vs-actual select. It holds a table of 2-bit saturating counters, indexed by PC (bimodal) or PC XOR global history (gshare). It gives a taken/not-taken prediction to fetch, trains on outcomes resolved in EX, and issues a registered redirect/flush with the recovery-path select. It sits between IF (prediction) and EX (resolution) of the pipelined core.

---
 rtl/branch_pred_unit_if.sv | 31 +++
 rtl/branch_pred_unit.sv | 94 +++++++++
 tb/tb_branch_pred_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_pred_unit_if.sv
// Predict/resolve/redirect bundle between the pipeline and the branch predictor.
// The core side drives the master modport and the predictor implements the slave modport.
interface branch_pred_unit_if #(
  parameter int PC_W   = 32,
  parameter int HIST_W = 6,
  parameter int CNT_W  = 16
);
  logic              pred_valid;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_taken;
  logic [HIST_W-1:0] pred_hist;
  logic              res_valid;
  logic [PC_W-1:0]   res_pc;
  logic [HIST_W-1:0] res_hist;
  logic              res_taken;
  logic              res_pred_taken;
  logic              redirect;
  logic              redirect_sel;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  mis_cnt;

  modport master (
    output pred_valid, pred_pc, res_valid, res_pc, res_hist, res_taken, res_pred_taken,
    input  pred_taken, pred_hist, redirect, redirect_sel, br_cnt, mis_cnt
  );

  modport slave (
    input  pred_valid, pred_pc, res_valid, res_pc, res_hist, res_taken, res_pred_taken,
    output pred_taken, pred_hist, redirect, redirect_sel, br_cnt, mis_cnt
  );
endinterface

// File: rtl/branch_pred_unit.sv
// 2-bit saturating-counter predictor (bimodal or gshare); prediction is combinational, redirect lands 1 cycle after resolve.
// No backpressure: one prediction and one resolution are accepted every cycle.
module branch_pred_unit #(
  parameter int IDX_W  = 6,
  parameter int PC_W   = 32,
  parameter int HIST_W = 6,
  parameter bit GSHARE = 1'b1,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  branch_pred_unit_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]        ctr_q [ENTRIES];
  logic [1:0]        ctr_d [ENTRIES];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic              redirect_q, redirect_d;
  logic              redirect_sel_q, redirect_sel_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;
  logic [IDX_W-1:0]  pred_idx;
  logic [IDX_W-1:0]  res_idx;
  logic [1:0]        res_ctr;
  logic              mispredict;

  // PC bits [1:0] are always zero for aligned branches, so they never reach the index.
  function automatic logic [IDX_W-1:0] idx_f(input logic [IDX_W-1:0] pc_bits,
                                             input logic [HIST_W-1:0] hist);
    logic [IDX_W-1:0] h_ext;
    h_ext = GSHARE ? IDX_W'(hist) : '0;
    return pc_bits ^ h_ext;
  endfunction

  assign pred_idx   = idx_f(bus.pred_pc[IDX_W+1:2], ghr_q);
  assign res_idx    = idx_f(bus.res_pc[IDX_W+1:2], bus.res_hist);
  assign res_ctr    = ctr_q[res_idx];
  assign mispredict = bus.res_valid && (bus.res_taken != bus.res_pred_taken);

  always_comb begin
    ctr_d          = ctr_q;
    ghr_d          = ghr_q;
    br_cnt_d       = br_cnt_q;
    mis_cnt_d      = mis_cnt_q;
    redirect_d     = mispredict;
    redirect_sel_d = mispredict ? bus.res_pred_taken : redirect_sel_q;

    if (bus.res_valid) begin
      if (bus.res_taken && (res_ctr != 2'b11)) begin
        ctr_d[res_idx] = res_ctr + 2'b01;
      end else if (!bus.res_taken && (res_ctr != 2'b00)) begin
        ctr_d[res_idx] = res_ctr - 2'b01;
      end
      // Oldest outcome falls off the MSB end.
      ghr_d = HIST_W'({ghr_q, bus.res_taken});
      if (br_cnt_q != '1) begin
        br_cnt_d = br_cnt_q + 1'b1;
      end
    end

    if (mispredict && (mis_cnt_q != '1)) begin
      mis_cnt_d = mis_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
      ghr_q          <= '0;
      redirect_q     <= 1'b0;
      redirect_sel_q <= 1'b0;
      br_cnt_q       <= '0;
      mis_cnt_q      <= '0;
    end else begin
      ctr_q          <= ctr_d;
      ghr_q          <= ghr_d;
      redirect_q     <= redirect_d;
      redirect_sel_q <= redirect_sel_d;
      br_cnt_q       <= br_cnt_d;
      mis_cnt_q      <= mis_cnt_d;
    end
  end

  // Table read is the pre-update value when predict and train hit the same entry.
  assign bus.pred_taken   = bus.pred_valid & ctr_q[pred_idx][1];
  assign bus.pred_hist    = ghr_q;
  assign bus.redirect     = redirect_q;
  assign bus.redirect_sel = redirect_sel_q;
  assign bus.br_cnt       = br_cnt_q;
  assign bus.mis_cnt      = mis_cnt_q;
endmodule

// File: tb/tb_branch_pred_unit.sv
// Bench for branch_pred_unit: a bimodal instance (CNT_W=4) and a gshare instance.
// Expected redirect/select pairs are queued when a resolve is driven and compared after the next edge.
module tb_branch_pred_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_pred_unit_if #(.PC_W(32), .HIST_W(6), .CNT_W(4))  b ();
  branch_pred_unit_if #(.PC_W(32), .HIST_W(6), .CNT_W(16)) g ();

  branch_pred_unit #(.IDX_W(6), .PC_W(32), .HIST_W(6), .GSHARE(1'b0), .CNT_W(4)) u_bim (
    .clk(clk), .rst_n(rst_n), .bus(b.slave)
  );
  branch_pred_unit #(.IDX_W(6), .PC_W(32), .HIST_W(6), .GSHARE(1'b1), .CNT_W(16)) u_gsh (
    .clk(clk), .rst_n(rst_n), .bus(g.slave)
  );

  typedef struct packed {
    logic r;
    logic s;
  } redir_t;

  redir_t     rq[$];
  redir_t     e;
  int         n_cmp = 0;
  int         n_err = 0;
  logic       m_sel;
  int         m_br, m_mis;
  logic [5:0] m_ghr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    rq.delete();
    m_sel = 1'b0;
    m_br  = 0;
    m_mis = 0;
    m_ghr = '0;
  endtask

  // Drive one bimodal resolve and queue what the following edge must produce.
  task automatic b_res(input logic [31:0] pc, input logic taken, input logic pt);
    b.res_valid      = 1'b1;
    b.res_pc         = pc;
    b.res_hist       = m_ghr;
    b.res_taken      = taken;
    b.res_pred_taken = pt;
    if (taken != pt) begin
      m_sel = pt;
      if (m_mis < 15) m_mis++;
    end
    if (m_br < 15) m_br++;
    m_ghr = {m_ghr[4:0], taken};
    rq.push_back({taken != pt, m_sel});
  endtask

  task automatic b_idle();
    b.res_valid = 1'b0;
    rq.push_back({1'b0, m_sel});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_clear();
    n_cmp++;
    if ({b.redirect, b.redirect_sel, b.br_cnt, b.mis_cnt, b.pred_hist} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_state: redir=%b sel=%b br=%0d mis=%0d hist=%h, want all zero",
               b.redirect, b.redirect_sel, b.br_cnt, b.mis_cnt, b.pred_hist);
    end
    for (int pc = 0; pc <= 'hFC; pc += 4) begin
      b.pred_valid = 1'b1;
      b.pred_pc    = pc;
      g.pred_valid = 1'b1;
      g.pred_pc    = pc;
      #1;
      n_cmp++;
      if ({b.pred_taken, g.pred_taken} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_pred pc=%h: bim=%b gsh=%b, want 0", pc, b.pred_taken, g.pred_taken);
      end
    end
  endtask

  task automatic test_mispredict();
    // A: predicted taken, actually not taken
    b_res(32'h10, 1'b0, 1'b1);
    tick();
    b.res_valid = 1'b0;
    e = rq.pop_front();
    n_cmp++;
    if ({b.redirect, b.redirect_sel} !== e) begin
      n_err++;
      $display("FAIL mispredict_a: redir/sel=%b%b, want %b", b.redirect, b.redirect_sel, e);
    end
    n_cmp++;
    if (b.mis_cnt !== 4'd1 || b.br_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL mispredict_a_cnt: mis=%0d br=%0d, want 1 1", b.mis_cnt, b.br_cnt);
    end
    b_idle();
    tick();
    e = rq.pop_front();
    n_cmp++;
    if ({b.redirect, b.redirect_sel} !== e) begin
      n_err++;
      $display("FAIL redirect_one_cycle: redir/sel=%b%b, want %b", b.redirect, b.redirect_sel, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] tk;
    logic [3:0] pt;
    tk = 4'b0010;   // bit i = outcome of resolve i
    pt = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      b_res(32'h10 + 32'(i) * 4, tk[i], pt[i]);
      tick();
      e = rq.pop_front();
      n_cmp++;
      if ({b.redirect, b.redirect_sel} !== e) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: redir/sel=%b%b, want %b", i, b.redirect, b.redirect_sel, e);
      end
    end
    b.res_valid = 1'b0;
    n_cmp++;
    if (b.mis_cnt !== 4'(m_mis) || b.br_cnt !== 4'(m_br)) begin
      n_err++;
      $display("FAIL back_to_back_cnt: mis=%0d br=%0d, want %0d %0d", b.mis_cnt, b.br_cnt, m_mis, m_br);
    end
  endtask

  task automatic test_low_saturation();
    // pc 0x10 was driven not-taken twice: 01->00->00; two takens must reach 10
    for (int i = 0; i < 2; i++) begin
      b_res(32'h10, 1'b1, 1'b0);
      tick();
      e = rq.pop_front();
      n_cmp++;
      if ({b.redirect, b.redirect_sel} !== e) begin
        n_err++;
        $display("FAIL low_sat_redir[%0d]: redir/sel=%b%b, want %b", i, b.redirect, b.redirect_sel, e);
      end
    end
    b.res_valid  = 1'b0;
    b.pred_valid = 1'b1;
    b.pred_pc    = 32'h10;
    #1;
    n_cmp++;
    if (b.pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL low_saturation: pred=%b, want 1", b.pred_taken);
    end
  endtask

  task automatic test_training();
    logic [4:0] pre;
    logic [4:0] tk;
    pre = 5'b11110;   // prediction seen before each resolve: 01,10,11,11,10
    tk  = 5'b00111;
    b.pred_valid = 1'b1;
    b.pred_pc    = 32'h40;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        b.pred_valid = 1'b0;
        #1;
        n_cmp++;
        if (b.pred_taken !== 1'b0) begin
          n_err++;
          $display("FAIL pred_valid_gate: pred=%b, want 0", b.pred_taken);
        end
        b.pred_valid = 1'b1;
      end
      #1;
      n_cmp++;
      if (b.pred_taken !== pre[i]) begin
        n_err++;
        $display("FAIL train_pred[%0d]: pred=%b, want %b", i, b.pred_taken, pre[i]);
      end
      b_res(32'h40, tk[i], pre[i]);
      tick();
      e = rq.pop_front();
      n_cmp++;
      if ({b.redirect, b.redirect_sel} !== e) begin
        n_err++;
        $display("FAIL train_redir[%0d]: redir/sel=%b%b, want %b", i, b.redirect, b.redirect_sel, e);
      end
    end
    b.res_valid = 1'b0;
    #1;
    n_cmp++;
    if (b.pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL train_final: pred=%b, want 0", b.pred_taken);
    end
  endtask

  task automatic test_hazard();
    b.pred_valid = 1'b1;
    b.pred_pc    = 32'h80;
    b_res(32'h80, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (b.pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL hazard_same_cycle: pred=%b, want 0", b.pred_taken);
    end
    tick();
    b.res_valid = 1'b0;
    #1;
    n_cmp++;
    if (b.pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL hazard_next_cycle: pred=%b, want 1", b.pred_taken);
    end
    e = rq.pop_front();
    n_cmp++;
    if ({b.redirect, b.redirect_sel} !== e) begin
      n_err++;
      $display("FAIL hazard_redir: redir/sel=%b%b, want %b", b.redirect, b.redirect_sel, e);
    end
  endtask

  task automatic test_gshare();
    // pc 0x04 with hist 0x01 trains idx 0x00; ghr becomes 0x01
    g.pred_valid     = 1'b1;
    g.res_valid      = 1'b1;
    g.res_pc         = 32'h04;
    g.res_hist       = 6'h01;
    g.res_taken      = 1'b1;
    g.res_pred_taken = 1'b1;
    tick();
    g.res_valid = 1'b0;
    g.pred_pc   = 32'h04;
    #1;
    n_cmp++;
    if (g.pred_hist !== 6'h01 || g.pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL gsh_trained: hist=%h pred=%b, want 01 1", g.pred_hist, g.pred_taken);
    end
    g.pred_pc = 32'h00;
    #1;
    n_cmp++;
    if (g.pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL gsh_idx1_ghr1: pred=%b, want 0", g.pred_taken);
    end
    // six not-taken resolves at idx 0x08 shift the history back to zero
    for (int i = 0; i < 6; i++) begin
      g.res_valid      = 1'b1;
      g.res_pc         = 32'h20;
      g.res_hist       = 6'h00;
      g.res_taken      = 1'b0;
      g.res_pred_taken = 1'b0;
      tick();
    end
    g.res_valid = 1'b0;
    g.pred_pc   = 32'h04;
    #1;
    n_cmp++;
    if (g.pred_hist !== 6'h00 || g.pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL gsh_untouched: hist=%h pred=%b, want 00 0", g.pred_hist, g.pred_taken);
    end
    g.pred_pc = 32'h00;
    #1;
    n_cmp++;
    if (g.pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL gsh_alias: pred=%b, want 1", g.pred_taken);
    end
    for (int i = 0; i < 6; i++) begin
      g.res_valid      = 1'b1;
      g.res_pc         = 32'h20;
      g.res_hist       = 6'h00;
      g.res_taken      = 1'b1;
      g.res_pred_taken = 1'b1;
      tick();
    end
    g.res_valid = 1'b0;
    n_cmp++;
    if (g.pred_hist !== 6'h3F || g.br_cnt !== 16'd13 || g.mis_cnt !== 16'd0 || g.redirect !== 1'b0) begin
      n_err++;
      $display("FAIL gsh_history: hist=%h br=%0d mis=%0d redir=%b, want 3f 13 0 0",
               g.pred_hist, g.br_cnt, g.mis_cnt, g.redirect);
    end
  endtask

  task automatic test_stat_saturation();
    for (int i = 0; i < 20; i++) begin
      b_res(32'h30, 1'b0, 1'b1);
      tick();
      e = rq.pop_front();
      n_cmp++;
      if ({b.redirect, b.redirect_sel} !== e) begin
        n_err++;
        $display("FAIL sat_redir[%0d]: redir/sel=%b%b, want %b", i, b.redirect, b.redirect_sel, e);
      end
    end
    b.res_valid = 1'b0;
    n_cmp++;
    if (b.mis_cnt !== 4'd15 || b.br_cnt !== 4'd15) begin
      n_err++;
      $display("FAIL stat_saturate: mis=%0d br=%0d, want 15 15", b.mis_cnt, b.br_cnt);
    end
  endtask

  task automatic test_reset_mid();
    b_res(32'h44, 1'b1, 1'b0);
    tick();
    e = rq.pop_front();
    n_cmp++;
    if ({b.redirect, b.redirect_sel} !== e) begin
      n_err++;
      $display("FAIL pre_reset_redir: redir/sel=%b%b, want %b", b.redirect, b.redirect_sel, e);
    end
    // reset collides with another mispredict that would set redirect_sel=1
    rst_n            = 1'b0;
    b.res_valid      = 1'b1;
    b.res_pc         = 32'h48;
    b.res_taken      = 1'b0;
    b.res_pred_taken = 1'b1;
    tick();
    rst_n       = 1'b1;
    b.res_valid = 1'b0;
    model_clear();
    n_cmp++;
    if ({b.redirect, b.redirect_sel, b.br_cnt, b.mis_cnt, b.pred_hist, g.pred_hist} !== 22'h0) begin
      n_err++;
      $display("FAIL reset_mid_state: redir=%b sel=%b br=%0d mis=%0d hist=%h ghist=%h, want all zero",
               b.redirect, b.redirect_sel, b.br_cnt, b.mis_cnt, b.pred_hist, g.pred_hist);
    end
    for (int pc = 0; pc <= 'hFC; pc += 4) begin
      b.pred_valid = 1'b1;
      b.pred_pc    = pc;
      g.pred_valid = 1'b1;
      g.pred_pc    = pc;
      #1;
      n_cmp++;
      if ({b.pred_taken, g.pred_taken} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_mid_pred pc=%h: bim=%b gsh=%b, want 0", pc, b.pred_taken, g.pred_taken);
      end
    end
  endtask

  initial begin
    b.pred_valid = 1'b0; b.pred_pc = '0; b.res_valid = 1'b0; b.res_pc = '0;
    b.res_hist = '0; b.res_taken = 1'b0; b.res_pred_taken = 1'b0;
    g.pred_valid = 1'b0; g.pred_pc = '0; g.res_valid = 1'b0; g.res_pc = '0;
    g.res_hist = '0; g.res_taken = 1'b0; g.res_pred_taken = 1'b0;
    model_clear();

    test_reset();
    test_mispredict();
    test_back_to_back();
    test_low_saturation();
    test_training();
    test_hazard();
    test_gshare();
    test_stat_saturation();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
